id_ex_skid_reg: RTL and testbench

ID_EX_SKID_REG -- requirements
Module: id_ex_skid_reg

---
 rtl/id_ex_pkg.sv | 43 ++++
 rtl/id_ex_skid_reg.sv | 129 ++++++++++++
 tb/tb_id_ex_skid_reg.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_pkg.sv
// Shared types for the ID/EX pipeline register.
//
// Contents:
//   - ID_EX_* width constants. These match the default parameters of
//     id_ex_skid_reg.
//   - id_ex_bundle_t: the decoded instruction bundle that is handed from
//     decode to execute.
//   - id_ex_bubble(): returns a copy of a bundle with every side-effecting
//     control bit cleared, so that a bubble can never write state.
package id_ex_pkg;

    localparam int unsigned ID_EX_PC_W    = 32;
    localparam int unsigned ID_EX_XLEN    = 32;
    localparam int unsigned ID_EX_RADDR_W = 5;
    localparam int unsigned ID_EX_ALUOP_W = 5;

    typedef struct packed {
        logic [ID_EX_PC_W-1:0]    pc;
        logic [ID_EX_RADDR_W-1:0] rs1;
        logic [ID_EX_RADDR_W-1:0] rs2;
        logic [ID_EX_XLEN-1:0]    rd1;
        logic [ID_EX_XLEN-1:0]    rd2;
        logic [ID_EX_XLEN-1:0]    imm;
        logic                     alu_src;
        logic [ID_EX_ALUOP_W-1:0] alu_op;
        logic                     is_jump;
        logic                     reg_wrenable;
        logic [ID_EX_RADDR_W-1:0] write_reg;
        logic                     mem_wrenable;
        logic                     mem_to_reg;
    } id_ex_bundle_t;

    // Strip the bits that change architectural state or redirect the fetch.
    function automatic id_ex_bundle_t id_ex_bubble(input id_ex_bundle_t b);
        id_ex_bundle_t r;
        r              = b;
        r.is_jump      = 1'b0;
        r.reg_wrenable = 1'b0;
        r.mem_wrenable = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/id_ex_skid_reg.sv
// ID/EX pipeline register built as a two-entry skid buffer.
//
// Entry roles:
//   - The main entry drives out_bundle.
//   - The skid entry catches the one bundle that is accepted while main is
//     stalled.
//   - in_ready is registered as !skid_valid. It therefore has no
//     combinational path from out_ready.
//
// Ports:
//   clk, rst            rising-edge clock; synchronous active-high reset
//   in_valid/in_ready   decode-side handshake
//   in_bundle           decoded bundle
//   flush               kill every held bundle plus any bundle accepted
//                       this cycle
//   out_valid/out_ready execute-side handshake
//   out_bundle          bundle to execute; control bits are cleared when
//                       out_valid is 0
//   stall_cnt           (only when ID_EX_STALL_CNT_EN is defined) 32-bit
//                       count of the cycles with out_valid && !out_ready
//
// Optional feature macro: ID_EX_STALL_CNT_EN.
module id_ex_skid_reg
    import id_ex_pkg::*;
#(
    parameter int unsigned PC_W    = 32,
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RADDR_W = 5,
    parameter int unsigned ALUOP_W = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  id_ex_bundle_t in_bundle,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output id_ex_bundle_t out_bundle
`ifdef ID_EX_STALL_CNT_EN
    ,
    output logic [31:0]   stall_cnt
`endif
);

    // The bundle layout is fixed by the package.
    // Reject any override that disagrees with it.
    if (PC_W != ID_EX_PC_W || XLEN != ID_EX_XLEN || RADDR_W != ID_EX_RADDR_W ||
        ALUOP_W != ID_EX_ALUOP_W) begin : g_width_check
        $error("id_ex_skid_reg: parameters must match id_ex_pkg widths");
    end

    id_ex_bundle_t main_q, main_d;
    id_ex_bundle_t skid_q, skid_d;
    logic          main_valid_q, main_valid_d;
    logic          skid_valid_q, skid_valid_d;
    logic          in_xfer;

    assign in_ready  = ~skid_valid_q;
    assign in_xfer   = in_valid & in_ready;
    assign out_valid = main_valid_q;
    assign out_bundle = main_valid_q ? main_q : id_ex_bubble(main_q);

    // Invariant: skid_valid implies main_valid.
    // The skid entry is only written while main is held.
    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || out_ready) begin
            // Main is empty or is being drained this cycle.
            if (skid_valid_q) begin
                // in_ready is low, so no new bundle can arrive in this cycle.
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = in_xfer;
                if (in_xfer) begin
                    main_d = in_bundle;
                end
            end
        end else if (in_xfer) begin
            skid_d       = in_bundle;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Wraps naturally at 2^32. Flush does not clear it.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (main_valid_q && !out_ready) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// Self-checking bench for id_ex_skid_reg.
//
// Test structure:
//   1. A table of single-cycle vectors. Each vector holds the inputs for one
//      cycle and the outputs expected just after the next rising edge.
//   2. A randomised stream compared against a reference queue.
module tb_id_ex_skid_reg;
    import id_ex_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    id_ex_bundle_t in_bundle;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    id_ex_bundle_t out_bundle;
`ifdef ID_EX_STALL_CNT_EN
    logic [31:0]   stall_cnt;
`endif

    always #5 clk = ~clk;

    id_ex_skid_reg #(
        .PC_W    (32),
        .XLEN    (32),
        .RADDR_W (5),
        .ALUOP_W (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_bundle  (in_bundle),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_bundle (out_bundle)
`ifdef ID_EX_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    int n_vec  = 0;
    int n_fail = 0;

    // Every field is a distinct function of pc.
    // All three control bits are set, so that clearing them for a bubble
    // shows up in the comparison.
    function automatic id_ex_bundle_t make_bundle(input logic [31:0] pc);
        id_ex_bundle_t b;
        b.pc           = pc;
        b.rs1          = pc[4:0];
        b.rs2          = ~pc[4:0];
        b.rd1          = pc * 32'd7 + 32'd1;
        b.rd2          = pc ^ 32'hA5A5_5A5A;
        b.imm          = pc + 32'd100;
        b.alu_src      = pc[0];
        b.alu_op       = pc[6:2];
        b.is_jump      = 1'b1;
        b.reg_wrenable = 1'b1;
        b.write_reg    = pc[5:1];
        b.mem_wrenable = 1'b1;
        b.mem_to_reg   = pc[1];
        return b;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected outputs after the edge.
    // exp_zero: the whole out_bundle must be 0.
    // When exp_ov is 0 and exp_zero is 0, only the control bits are checked.
    typedef struct {
        logic        rst;
        logic        flush;
        logic        iv;
        logic [31:0] pc;
        logic        ordy;
        logic        exp_ov;
        logic        exp_ir;
        logic [31:0] exp_pc;
        logic        exp_zero;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic f, input logic iv, input int pc,
                                input logic ordy, input logic ov, input logic ir, input int epc,
                                input logic z);
        vec_t v;
        v.rst = r;      v.flush = f;   v.iv = iv;     v.pc = pc;       v.ordy = ordy;
        v.exp_ov = ov;  v.exp_ir = ir; v.exp_pc = epc; v.exp_zero = z;
        return v;
    endfunction

    logic [31:0] q[$];
    int unsigned stall_exp;
    logic [31:0] next_pc;
    logic        m_ir;
    logic        m_ov;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_bundle = make_bundle(32'd0);

        // Reset state.
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 1));

        // Full-throughput stream: latency 1, in_ready stays high.
        for (int i = 0; i < 10; i++) vecs.push_back(mk(0, 0, 1, i, 1, 1, 1, i, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 0));

        // Stall: 4 is held in main, 5 goes to skid, and 6 is refused.
        vecs.push_back(mk(0, 0, 1, 4, 0, 1, 1, 4, 0));
        vecs.push_back(mk(0, 0, 1, 5, 0, 1, 0, 4, 0));
        vecs.push_back(mk(0, 0, 1, 6, 0, 1, 0, 4, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1, 5, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 0));

        // Flush with both entries full while pc=10 is offered.
        vecs.push_back(mk(0, 0, 1, 8, 0, 1, 1, 8, 0));
        vecs.push_back(mk(0, 0, 1, 9, 0, 1, 0, 8, 0));
        vecs.push_back(mk(0, 1, 1, 10, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 0));

        // Flush in the cycle that accepts pc=12: pc=12 must be discarded.
        vecs.push_back(mk(0, 0, 1, 11, 0, 1, 1, 11, 0));
        vecs.push_back(mk(0, 1, 1, 12, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 0));

        // Reset during a stall with skid full.
        vecs.push_back(mk(0, 0, 1, 20, 0, 1, 1, 20, 0));
        vecs.push_back(mk(0, 0, 1, 21, 0, 1, 0, 20, 0));
        vecs.push_back(mk(1, 0, 1, 22, 0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 1));

        // Reset has priority over a simultaneous flush.
        // Traffic then resumes normally.
        vecs.push_back(mk(0, 0, 1, 30, 1, 1, 1, 30, 0));
        vecs.push_back(mk(1, 1, 1, 31, 1, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 1, 32, 1, 1, 1, 32, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 0));

        foreach (vecs[i]) begin
            rst       = vecs[i].rst;
            flush     = vecs[i].flush;
            in_valid  = vecs[i].iv;
            in_bundle = make_bundle(vecs[i].pc);
            out_ready = vecs[i].ordy;
            @(posedge clk);
            #1;
            check($sformatf("v%0d out_valid", i), 256'(out_valid), 256'(vecs[i].exp_ov));
            check($sformatf("v%0d in_ready", i), 256'(in_ready), 256'(vecs[i].exp_ir));
            if (vecs[i].exp_zero)
                check($sformatf("v%0d bundle_zero", i), 256'(out_bundle), 256'(0));
            else if (vecs[i].exp_ov)
                check($sformatf("v%0d bundle", i), 256'(out_bundle),
                      256'(make_bundle(vecs[i].exp_pc)));
            else
                check($sformatf("v%0d bubble_ctrl", i),
                      256'({out_bundle.is_jump, out_bundle.reg_wrenable,
                            out_bundle.mem_wrenable}), 256'(0));
        end

        // Random traffic against a reference FIFO of depth 2.
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        stall_exp = 0;
        next_pc = 32'd1000;
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 99) == 0);
            in_bundle = make_bundle(next_pc);
            @(negedge clk);
            m_ov = (q.size() > 0);
            m_ir = (q.size() < 2);
            if (out_valid !== m_ov || in_ready !== m_ir) begin
                check($sformatf("rnd%0d valid/ready", c), 256'({out_valid, in_ready}),
                      256'({m_ov, m_ir}));
            end else if (m_ov && out_ready) begin
                check($sformatf("rnd%0d bundle", c), 256'(out_bundle),
                      256'(make_bundle(q[0])));
            end else begin
                check($sformatf("rnd%0d valid/ready", c), 256'({out_valid, in_ready}),
                      256'({m_ov, m_ir}));
            end
            if (m_ov && !out_ready) stall_exp++;
            if (flush) begin
                q.delete();
                if (in_valid && m_ir) next_pc++;
            end else begin
                if (m_ov && out_ready) void'(q.pop_front());
                if (in_valid && m_ir) begin
                    q.push_back(next_pc);
                    next_pc++;
                end
            end
            @(posedge clk);
            #1;
        end
`ifdef ID_EX_STALL_CNT_EN
        check("stall_cnt", 256'(stall_cnt), 256'(stall_exp));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
